// File: rtl/seven_seg_scan_driver_if.sv
// Control-side bundle of the seven-segment scan driver: display values, load strobe, frame_done.
// Optional BLINK_EN adds blink_mask to both modports.
`default_nettype none

interface seven_seg_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] digits;
    logic [DIGITS-1:0]   dp_mask;
    logic                blank_lz;
    logic                load;
    logic                frame_done;
`ifdef BLINK_EN
    logic [DIGITS-1:0]   blink_mask;

    modport master (output digits, dp_mask, blank_lz, load, blink_mask, input frame_done);
    modport slave  (input digits, dp_mask, blank_lz, load, blink_mask, output frame_done);
`else
    modport master (output digits, dp_mask, blank_lz, load, input frame_done);
    modport slave  (input digits, dp_mask, blank_lz, load, output frame_done);
`endif
endinterface

`default_nettype wire

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: multiplexed hex display scanner with guard gap, LZ blanking and tear-free loads.
// Optional feature macro: BLINK_EN (blink_mask input, BLINK_FREQ parameter).
`default_nettype none

module seven_seg_scan_driver #(
    parameter int DIGITS         = 4,
    parameter int CLK_FREQ       = 1000000,
    parameter int SCAN_FREQ      = 250,
    parameter int GUARD          = 2,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int COM_ACTIVE_LOW = 1
`ifdef BLINK_EN
    ,
    parameter int BLINK_FREQ     = 2
`endif
) (
    input  logic                     clk,
    input  logic                     reset,
    seven_seg_scan_driver_if.slave   bus,
    output logic [DIGITS-1:0]        com,
    output logic [7:0]               seg
);
    localparam int DIV = CLK_FREQ / SCAN_FREQ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0]     DIV_M1  = PW'(DIV - 1);
    localparam logic [PW-1:0]     GUARD_V = PW'(GUARD);
    localparam logic [IW-1:0]     IDX_MAX = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] COM_OFF = (COM_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [7:0]        SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    logic [PW-1:0]       presc_q, presc_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] act_dig_q, act_dig_d, pend_dig_q, pend_dig_d;
    logic [DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
    logic                act_blz_q, act_blz_d, pend_blz_q, pend_blz_d;
    logic                pend_flag_q, pend_flag_d;
    logic                frame_done_q, frame_done_d;
    logic [DIGITS-1:0]   com_q, com_d;
    logic [7:0]          seg_q, seg_d;
    logic                tick, wrap;
    logic [DIGITS-1:0]   blank_vec, onehot;
    logic                all_zero;
    logic [3:0]          cur_digit;
    logic [7:0]          seg_lit;
    logic                blink_hide;

    // Segment pattern {g,f,e,d,c,b,a}, lit = 1.
    function automatic logic [6:0] decode(input logic [3:0] h);
        case (h)
            4'h0: decode = 7'h3F;  4'h1: decode = 7'h06;  4'h2: decode = 7'h5B;  4'h3: decode = 7'h4F;
            4'h4: decode = 7'h66;  4'h5: decode = 7'h6D;  4'h6: decode = 7'h7D;  4'h7: decode = 7'h07;
            4'h8: decode = 7'h7F;  4'h9: decode = 7'h6F;  4'hA: decode = 7'h77;  4'hB: decode = 7'h7C;
            4'hC: decode = 7'h39;  4'hD: decode = 7'h5E;  4'hE: decode = 7'h79;  default: decode = 7'h71;
        endcase
    endfunction

    assign tick = (presc_q == DIV_M1);
    assign wrap = tick && (idx_q == IDX_MAX);

`ifdef BLINK_EN
    localparam int BHALF = CLK_FREQ / (2 * BLINK_FREQ);
    localparam int BW    = (BHALF > 1) ? $clog2(BHALF) : 1;
    localparam logic [BW-1:0] BHALF_M1 = BW'(BHALF - 1);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_off_q, blink_off_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_off_d = blink_off_q;
        if (blink_cnt_q == BHALF_M1) begin
            blink_cnt_d = '0;
            blink_off_d = ~blink_off_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt_q <= '0;
            blink_off_q <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_off_q <= blink_off_d;
        end
    end

    assign blink_hide = blink_off_d && bus.blink_mask[idx_d];
`else
    assign blink_hide = 1'b0;
`endif

    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        idx_d   = idx_q;
        if (tick) idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;

        // Active takes the pending copy at the wrap; a load on that same edge waits one more frame.
        act_dig_d    = act_dig_q;
        act_dp_d     = act_dp_q;
        act_blz_d    = act_blz_q;
        frame_done_d = 1'b0;
        pend_flag_d  = pend_flag_q;
        if (wrap && pend_flag_q) begin
            act_dig_d    = pend_dig_q;
            act_dp_d     = pend_dp_q;
            act_blz_d    = pend_blz_q;
            frame_done_d = 1'b1;
            pend_flag_d  = 1'b0;
        end
        pend_dig_d = pend_dig_q;
        pend_dp_d  = pend_dp_q;
        pend_blz_d = pend_blz_q;
        if (bus.load) begin
            pend_dig_d  = bus.digits;
            pend_dp_d   = bus.dp_mask;
            pend_blz_d  = bus.blank_lz;
            pend_flag_d = 1'b1;
        end

        all_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            all_zero     = all_zero && (act_dig_d[4*i +: 4] == 4'h0);
            blank_vec[i] = act_blz_d && all_zero && (i != 0);
        end

        // Outputs are computed for the next cycle's slot position so they register in step with it.
        onehot         = '0;
        onehot[idx_d]  = 1'b1;
        cur_digit      = act_dig_d[4*idx_d +: 4];
        seg_lit        = {act_dp_d[idx_d], blank_vec[idx_d] ? 7'h00 : decode(cur_digit)};
        com_d          = COM_OFF;
        seg_d          = SEG_OFF;
        if (presc_d >= GUARD_V) begin
            com_d = (COM_ACTIVE_LOW != 0) ? ~onehot : onehot;
            if (!blink_hide) seg_d = (SEG_ACTIVE_LOW != 0) ? ~seg_lit : seg_lit;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q      <= '0;
            idx_q        <= '0;
            act_dig_q    <= '0;
            act_dp_q     <= '0;
            act_blz_q    <= 1'b0;
            pend_dig_q   <= '0;
            pend_dp_q    <= '0;
            pend_blz_q   <= 1'b0;
            pend_flag_q  <= 1'b0;
            frame_done_q <= 1'b0;
            com_q        <= COM_OFF;
            seg_q        <= SEG_OFF;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            act_dig_q    <= act_dig_d;
            act_dp_q     <= act_dp_d;
            act_blz_q    <= act_blz_d;
            pend_dig_q   <= pend_dig_d;
            pend_dp_q    <= pend_dp_d;
            pend_blz_q   <= pend_blz_d;
            pend_flag_q  <= pend_flag_d;
            frame_done_q <= frame_done_d;
            com_q        <= com_d;
            seg_q        <= seg_d;
        end
    end

    assign bus.frame_done = frame_done_q;
    assign com            = com_q;
    assign seg            = seg_q;

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_scan_driver.sv
// Testbench for seven_seg_scan_driver: directed and random loads checked cycle by cycle against a frame-level model.
`default_nettype none

module tb_seven_seg_scan_driver;
    localparam int DIGITS = 4;
    localparam int DIV    = 10;
    localparam int GUARD  = 2;
    localparam int FRAME  = DIV * DIGITS;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [DIGITS-1:0] com;
    logic [7:0]        seg;

    seven_seg_scan_driver_if #(.DIGITS(DIGITS)) bus_if ();

    seven_seg_scan_driver #(
        .DIGITS(DIGITS), .CLK_FREQ(1000), .SCAN_FREQ(100), .GUARD(GUARD),
        .SEG_ACTIVE_LOW(1), .COM_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus_if.slave), .com(com), .seg(seg)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: cycle count since reset release, active/pending display values, pending flag.
    int          n;
    logic [15:0] m_dg, p_dg;
    logic [3:0]  m_dp, p_dp;
    logic        m_bz, p_bz, p_flag, exp_fd;
    logic [6:0]  glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic model_reset();
        n = 0; m_dg = '0; p_dg = '0; m_dp = '0; p_dp = '0;
        m_bz = 0; p_bz = 0; p_flag = 0; exp_fd = 0;
    endtask

    function automatic logic [3:0] exp_com_f();
        int pos = n % DIV;
        int slot = (n / DIV) % DIGITS;
        if (pos < GUARD) return 4'hF;
        return ~(4'(1) << slot);
    endfunction

    function automatic logic [7:0] exp_seg_f();
        int pos = n % DIV;
        int slot = (n / DIV) % DIGITS;
        logic [15:0] upper;
        logic [7:0]  lit;
        if (pos < GUARD) return 8'hFF;
        upper = m_dg >> (4 * slot);
        lit = {m_dp[slot], 7'h00};
        if (!(m_bz && slot > 0 && upper == 16'h0)) lit[6:0] = glyph_tab[upper[3:0]];
        return ~lit;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s at n=%0d observed=%h expected=%h", tag, n, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("com", 32'(com), 32'(exp_com_f()));
        check("seg", 32'(seg), 32'(exp_seg_f()));
        check("frame_done", 32'(bus_if.frame_done), 32'(exp_fd));
    endtask

    // One clock edge; inputs are applied before it, model advanced and outputs checked 1 time unit after.
    task automatic step(input bit ld, input logic [15:0] dg, input logic [3:0] dm, input bit bz);
        bus_if.load = ld;
        if (ld) begin
            bus_if.digits = dg; bus_if.dp_mask = dm; bus_if.blank_lz = bz;
        end
        @(posedge clk); #1;
        exp_fd = 0;
        if ((n + 1) % FRAME == 0 && p_flag) begin
            m_dg = p_dg; m_dp = p_dp; m_bz = p_bz; p_flag = 0; exp_fd = 1;
        end
        if (ld) begin
            p_dg = dg; p_dp = dm; p_bz = bz; p_flag = 1;
        end
        n++;
        bus_if.load = 1'b0;
        check_outputs();
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 16'h0, 4'h0, 1'b0);
    endtask

    initial begin
        bus_if.digits = '0; bus_if.dp_mask = '0; bus_if.blank_lz = 0; bus_if.load = 0;
`ifdef BLINK_EN
        bus_if.blink_mask = '0;
`endif
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_com", 32'(com), 32'hF);
        check("reset_seg", 32'(seg), 32'hFF);
        check("reset_fd", 32'(bus_if.frame_done), 32'h0);
        reset = 1'b1;
        check_outputs();
        idle(45);

        step(1'b1, 16'h12AF, 4'b0100, 1'b0);
        idle(85);
        step(1'b1, 16'h0005, 4'b0000, 1'b1);
        idle(85);
        step(1'b1, 16'h0000, 4'b0000, 1'b1);
        idle(85);

        step(1'b1, 16'h1111, 4'b0000, 1'b0);
        idle(3);
        step(1'b1, 16'h2222, 4'b0000, 1'b0);
        idle(85);

        // Land a load exactly on the wrap-tick edge.
        for (int i = 0; i < FRAME && (n % FRAME) != FRAME - 1; i++) idle(1);
        check("sync_wrap_phase", 32'(n % FRAME), 32'(FRAME - 1));
        step(1'b1, 16'h3C5A, 4'b1010, 1'b0);
        idle(85);

        idle(13);
        reset = 1'b0;
        #1;
        check("midreset_com", 32'(com), 32'hF);
        check("midreset_seg", 32'(seg), 32'hFF);
        @(posedge clk); #1;
        check("midreset_hold_com", 32'(com), 32'hF);
        reset = 1'b1;
        model_reset();
        check_outputs();
        idle(45);

        for (int k = 0; k < 12; k++) begin
            idle($urandom_range(0, 50));
            step(1'b1, 16'($urandom), 4'($urandom), 1'($urandom));
        end
        idle(85);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
